// File: rtl/me_dcache_port.sv
// MEM-stage data-cache initiator: turns EX/MEM loads/stores into one valid/ready request and extends load data.
// Optional build macro MEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of truncating.
module me_dcache_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  me_write_ram_flag,
    input  logic [2:0]  me_load_ram_flag,
    input  logic [31:0] me_alu_out,
    input  logic [31:0] me_rs2_data,
    output logic        dc_req_valid,
    input  logic        dc_req_ready,
    output logic        dc_req_we,
    output logic [31:0] dc_req_addr,
    output logic [31:0] dc_req_wdata,
    output logic [3:0]  dc_req_wstrb,
    input  logic        dc_resp_valid,
    input  logic [31:0] dc_resp_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_load_data,
    output logic        mem_done,
    output logic        dc_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        is_store;
    logic        is_load;
    logic        acc;
    logic        misalign;
    logic        timeout;
    logic [15:0] tmo_cnt;
    logic [2:0]  lat_lt;
    logic [1:0]  lat_a;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;
    logic [31:0] ext_data;
    logic [1:0]  a;

    assign a = me_alu_out[1:0];

    always_comb begin
        is_store = (me_write_ram_flag != 2'd0);
        is_load  = (me_load_ram_flag != 3'd0) && (me_load_ram_flag <= 3'd5);
        acc      = is_store || is_load;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (is_store) begin
            if (me_write_ram_flag == 2'd2)
                misalign = a[0];
            else if (me_write_ram_flag == 2'd3)
                misalign = (a != 2'd0);
        end else if (is_load) begin
            if (me_load_ram_flag == 3'd3 || me_load_ram_flag == 3'd4)
                misalign = a[0];
            else if (me_load_ram_flag == 3'd5)
                misalign = (a != 2'd0);
        end
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        wstrb_c = 4'h0;
        wdata_c = 32'h0;
        case (me_write_ram_flag)
            2'd1: begin
                wstrb_c = 4'b0001 << a;
                wdata_c = {4{me_rs2_data[7:0]}};
            end
            2'd2: begin
                wstrb_c = 4'b0011 << {a[1], 1'b0};
                wdata_c = {2{me_rs2_data[15:0]}};
            end
            2'd3: begin
                wstrb_c = 4'hF;
                wdata_c = me_rs2_data;
            end
            default: ;
        endcase
    end

    // Timeout fires on the WAIT cycle that completes TIMEOUT_CYCLES response-less cycles.
    assign timeout = ({16'd0, tmo_cnt} + 32'd1) >= 32'(TIMEOUT_CYCLES);

    always_comb begin
        state_nxt    = state;
        dc_req_valid = 1'b0;
        mem_done     = 1'b0;
        mem_stall    = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc && !flush) begin
                    mem_stall = 1'b1;
                    state_nxt = misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                dc_req_valid = 1'b1;
                mem_stall    = 1'b1;
                if (dc_req_ready)
                    state_nxt = S_WAIT;
                else if (flush)
                    state_nxt = S_IDLE;
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (dc_resp_valid || timeout)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                mem_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ext_data = 32'h0;
        case (lat_lt)
            3'd1, 3'd2: begin
                logic [7:0] b;
                case (lat_a)
                    2'd0:    b = dc_resp_rdata[7:0];
                    2'd1:    b = dc_resp_rdata[15:8];
                    2'd2:    b = dc_resp_rdata[23:16];
                    default: b = dc_resp_rdata[31:24];
                endcase
                ext_data = {{24{b[7] && (lat_lt == 3'd1)}}, b};
            end
            3'd3, 3'd4: begin
                logic [15:0] h;
                h = lat_a[1] ? dc_resp_rdata[31:16] : dc_resp_rdata[15:0];
                ext_data = {{16{h[15] && (lat_lt == 3'd3)}}, h};
            end
            3'd5:    ext_data = dc_resp_rdata;
            default: ext_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            tmo_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == S_REQ && dc_req_ready)
                tmo_cnt <= 16'd0;
            else if (state == S_WAIT && tmo_cnt != 16'hFFFF)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Request fields are captured once so they stay stable however long the cache withholds ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dc_req_addr  <= 32'h0;
            dc_req_we    <= 1'b0;
            dc_req_wdata <= 32'h0;
            dc_req_wstrb <= 4'h0;
            lat_lt       <= 3'd0;
            lat_a        <= 2'd0;
        end else if (state == S_IDLE && acc && !flush) begin
            dc_req_addr  <= {me_alu_out[31:2], 2'b00};
            dc_req_we    <= is_store;
            dc_req_wdata <= wdata_c;
            dc_req_wstrb <= wstrb_c;
            lat_lt       <= is_store ? 3'd0 : me_load_ram_flag;
            lat_a        <= a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_load_data <= 32'h0;
            dc_err        <= 1'b0;
        end else if (state == S_IDLE && state_nxt == S_DONE) begin
            mem_load_data <= 32'h0;
            dc_err        <= 1'b1;
        end else if (state == S_WAIT && dc_resp_valid) begin
            mem_load_data <= ext_data;
        end else if (state == S_WAIT && timeout) begin
            mem_load_data <= 32'h0;
            dc_err        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_me_dcache_port.sv
// Scoreboard bench for me_dcache_port: stimulus pushes expected requests/completions, a monitor pops and compares.
module tb_me_dcache_port;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic        chk_data;
        logic        err;
    } done_exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  me_write_ram_flag;
    logic [2:0]  me_load_ram_flag;
    logic [31:0] me_alu_out;
    logic [31:0] me_rs2_data;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic        dc_req_we;
    logic [31:0] dc_req_addr;
    logic [31:0] dc_req_wdata;
    logic [3:0]  dc_req_wstrb;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_rdata;
    logic        mem_stall;
    logic [31:0] mem_load_data;
    logic        mem_done;
    logic        dc_err;

    logic        resp_en;
    logic [31:0] resp_data;
    logic        resp_hs;
    logic        exp_err;

    req_exp_t    req_q[$];
    done_exp_t   done_q[$];
    int          compared;
    int          mismatched;

    me_dcache_port #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .me_write_ram_flag (me_write_ram_flag),
        .me_load_ram_flag  (me_load_ram_flag),
        .me_alu_out        (me_alu_out),
        .me_rs2_data       (me_rs2_data),
        .dc_req_valid      (dc_req_valid),
        .dc_req_ready      (dc_req_ready),
        .dc_req_we         (dc_req_we),
        .dc_req_addr       (dc_req_addr),
        .dc_req_wdata      (dc_req_wdata),
        .dc_req_wstrb      (dc_req_wstrb),
        .dc_resp_valid     (dc_resp_valid),
        .dc_resp_rdata     (dc_resp_rdata),
        .mem_stall         (mem_stall),
        .mem_load_data     (mem_load_data),
        .mem_done          (mem_done),
        .dc_err            (dc_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: event not as expected", name);
    endtask

    task automatic expectReq(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [3:0] wstrb);
        req_exp_t e;
        e.addr = addr; e.we = we; e.wdata = wdata; e.wstrb = wstrb;
        req_q.push_back(e);
    endtask

    task automatic expectDone(input logic [31:0] data, input logic chk_data, input logic err);
        done_exp_t e;
        e.data = data; e.chk_data = chk_data; e.err = err;
        done_q.push_back(e);
    endtask

    // Called right after a rising edge; returns stalled-cycle count and the cycle mem_done was seen.
    task automatic applyStimulus(input logic [1:0] wf, input logic [2:0] lf, input logic [31:0] addr,
                                 input logic [31:0] rs2, input logic [31:0] rdata, input logic respond,
                                 output int stall_cycles, output int done_cycle);
        me_write_ram_flag = wf;
        me_load_ram_flag  = lf;
        me_alu_out        = addr;
        me_rs2_data       = rs2;
        resp_data         = rdata;
        resp_en           = respond;
        dc_req_ready      = 1'b1;
        stall_cycles      = 0;
        done_cycle        = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_stall) stall_cycles++;
            if (mem_done) done_cycle = c;
            @(posedge clk); #1;
            if (done_cycle != 0) break;
        end
        me_write_ram_flag = 2'd0;
        me_load_ram_flag  = 3'd0;
        if (done_cycle == 0) reportFail("done_wait_bound");
    endtask

    // Cache model: answers in the cycle after acceptance when enabled.
    initial begin
        dc_resp_valid = 1'b0;
        dc_resp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            resp_hs = dc_req_valid && dc_req_ready && rst;
            @(posedge clk); #1;
            dc_resp_valid = resp_hs && resp_en;
            dc_resp_rdata = resp_hs ? resp_data : 32'h0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && dc_req_valid && dc_req_ready) begin
                if (req_q.size() == 0) begin
                    reportFail("unexpected_req");
                end else begin
                    req_exp_t e;
                    e = req_q.pop_front();
                    checkOutput("req_addr", dc_req_addr, e.addr);
                    checkOutput("req_we", {31'd0, dc_req_we}, {31'd0, e.we});
                    checkOutput("req_wstrb", {28'd0, dc_req_wstrb}, {28'd0, e.wstrb});
                    if (e.we) checkOutput("req_wdata", dc_req_wdata, e.wdata);
                end
            end
            if (rst && mem_done) begin
                if (done_q.size() == 0) begin
                    reportFail("unexpected_done");
                end else begin
                    done_exp_t e;
                    e = done_q.pop_front();
                    if (e.chk_data) checkOutput("load_data", mem_load_data, e.data);
                    checkOutput("dc_err", {31'd0, dc_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int st;
        int dn;
        compared          = 0;
        mismatched        = 0;
        exp_err           = 1'b0;
        rst               = 1'b0;
        flush             = 1'b0;
        me_write_ram_flag = 2'd0;
        me_load_ram_flag  = 3'd0;
        me_alu_out        = 32'h0;
        me_rs2_data       = 32'h0;
        dc_req_ready      = 1'b0;
        resp_en           = 1'b0;
        resp_data         = 32'h0;

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_ctrl", {27'd0, dc_req_valid, dc_req_we, mem_stall, mem_done, dc_err}, 32'h0);
        checkOutput("rst_addr", dc_req_addr, 32'h0);
        checkOutput("rst_wdata", dc_req_wdata, 32'h0);
        checkOutput("rst_wstrb", {28'd0, dc_req_wstrb}, 32'h0);
        checkOutput("rst_load_data", mem_load_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        expectReq(32'h100, 1'b1, 32'hDEADBEEF, 4'hF);
        expectDone(32'h0, 1'b0, 1'b0);
        applyStimulus(2'd3, 3'd0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b1, st, dn);
        checkOutput("sw_stall_cycles", st, 3);
        checkOutput("sw_done_cycle", dn, 4);

        expectReq(32'h100, 1'b1, 32'hA5A5A5A5, 4'b1000);
        expectDone(32'h0, 1'b0, 1'b0);
        applyStimulus(2'd1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 1'b1, st, dn);

        expectReq(32'h104, 1'b1, 32'hBEEFBEEF, 4'b1100);
        expectDone(32'h0, 1'b0, 1'b0);
        applyStimulus(2'd2, 3'd0, 32'h106, 32'h1234BEEF, 32'h0, 1'b1, st, dn);

        expectReq(32'h200, 1'b0, 32'h0, 4'h0);
        expectDone(32'hFFFFFF80, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd1, 32'h202, 32'h0, 32'h1280FF34, 1'b1, st, dn);
        checkOutput("load_data_held", mem_load_data, 32'hFFFFFF80);

        expectReq(32'h200, 1'b0, 32'h0, 4'h0);
        expectDone(32'h00000080, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd2, 32'h202, 32'h0, 32'h1280FF34, 1'b1, st, dn);

        expectReq(32'h200, 1'b0, 32'h0, 4'h0);
        expectDone(32'h00001280, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd3, 32'h202, 32'h0, 32'h1280FF34, 1'b1, st, dn);

        expectReq(32'h200, 1'b0, 32'h0, 4'h0);
        expectDone(32'hFFFFF00D, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd3, 32'h200, 32'h0, 32'h1234F00D, 1'b1, st, dn);

        expectReq(32'h200, 1'b0, 32'h0, 4'h0);
        expectDone(32'h0000F00D, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd4, 32'h200, 32'h0, 32'h1234F00D, 1'b1, st, dn);

        expectReq(32'h200, 1'b0, 32'h0, 4'h0);
        expectDone(32'h00000034, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd1, 32'h200, 32'h0, 32'h1280FF34, 1'b1, st, dn);

        expectReq(32'h300, 1'b1, 32'h11223344, 4'hF);
        expectDone(32'h0, 1'b0, 1'b0);
        applyStimulus(2'd3, 3'd5, 32'h300, 32'h11223344, 32'h0, 1'b1, st, dn);

        // Load type 6 is not an access: no request, no stall.
        me_load_ram_flag = 3'd6;
        me_alu_out       = 32'h600;
        @(negedge clk);
        checkOutput("lt6_stall", {31'd0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        me_load_ram_flag = 3'd0;

        // Flush while the cache withholds ready: request abandoned, nothing handshakes.
        me_load_ram_flag = 3'd5;
        me_alu_out       = 32'h400;
        dc_req_ready     = 1'b0;
        resp_en          = 1'b1;
        @(negedge clk);
        checkOutput("flush_c1_stall", {31'd0, mem_stall}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("flush_c2_valid", {31'd0, dc_req_valid}, 32'h1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_c3_valid", {31'd0, dc_req_valid}, 32'h1);
        checkOutput("flush_c3_addr", dc_req_addr, 32'h400);
        @(posedge clk); #1;
        flush            = 1'b0;
        me_load_ram_flag = 3'd0;
        @(negedge clk);
        checkOutput("flush_c4_valid", {31'd0, dc_req_valid}, 32'h0);
        checkOutput("flush_c4_stall", {31'd0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;

        expectReq(32'h404, 1'b0, 32'h0, 4'h0);
        expectDone(32'hCAFEF00D, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd5, 32'h404, 32'h0, 32'hCAFEF00D, 1'b1, st, dn);
        checkOutput("lw_after_flush_done_cycle", dn, 4);

`ifdef MEM_MISALIGN_TRAP_EN
        expectDone(32'h0, 1'b1, 1'b1);
        applyStimulus(2'd0, 3'd5, 32'h102, 32'h0, 32'h55667788, 1'b1, st, dn);
        checkOutput("misalign_done_cycle", dn, 2);
        checkOutput("misalign_stall_cycles", st, 1);
`else
        expectReq(32'h100, 1'b0, 32'h0, 4'h0);
        expectDone(32'h55667788, 1'b1, 1'b0);
        applyStimulus(2'd0, 3'd5, 32'h102, 32'h0, 32'h55667788, 1'b1, st, dn);
        checkOutput("unaligned_lw_done_cycle", dn, 4);
`endif

        expectReq(32'h500, 1'b0, 32'h0, 4'h0);
        expectDone(32'h0, 1'b1, 1'b1);
        applyStimulus(2'd0, 3'd5, 32'h500, 32'h0, 32'h77777777, 1'b0, st, dn);
        checkOutput("timeout_done_cycle", dn, 7);
        checkOutput("timeout_stall_cycles", st, 6);
        checkOutput("timeout_err_sticky", {31'd0, dc_err}, 32'h1);

        // Second run: reset lands in WAIT and must clear everything without a clock edge.
        expectReq(32'h504, 1'b0, 32'h0, 4'h0);
        me_load_ram_flag = 3'd5;
        me_alu_out       = 32'h504;
        dc_req_ready     = 1'b1;
        resp_en          = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wait_run_valid", {31'd0, dc_req_valid}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wait_run_stall", {31'd0, mem_stall}, 32'h1);
        #2;
        rst              = 1'b0;
        me_load_ram_flag = 3'd0;
        #1;
        checkOutput("async_rst_ctrl", {27'd0, dc_req_valid, dc_req_we, mem_stall, mem_done, dc_err}, 32'h0);
        checkOutput("async_rst_addr", dc_req_addr, 32'h0);
        checkOutput("async_rst_wstrb", {28'd0, dc_req_wstrb}, 32'h0);
        checkOutput("async_rst_load_data", mem_load_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_rst_err", {31'd0, dc_err}, 32'h0);
        checkOutput("req_q_drained", req_q.size(), 0);
        checkOutput("done_q_drained", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
